mini_src_control_unit: RTL and testbench

//  Hardwired Moore control sequencer for the Mini SRC datapath. Generates T-state control strobes for fetch (T0-T2) and
//  R-format execute (T3-T5/T6). Decodes IR fields into one-hot register out/in selects. Replaces hand-driven bench strobes.

---
 rtl/mini_src_pkg.sv | 65 ++++++
 rtl/mini_src_control_unit_reg_select.sv | 15 +
 rtl/mini_src_control_unit.sv | 166 ++++++++++++++++
 tb/tb_mini_src_control_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Mini SRC control definitions: opcodes, ALU codes, sequencer states and decode helpers.
// MUL/DIV legality follows the CU_MULDIV_EN build macro.
package mini_src_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_SHR = 5'b00101;
  localparam logic [4:0] ALU_SHL = 5'b00111;
  localparam logic [4:0] ALU_ROR = 5'b01000;
  localparam logic [4:0] ALU_ROL = 5'b01001;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;
  localparam logic [4:0] ALU_MUL = 5'b01111;
  localparam logic [4:0] ALU_DIV = 5'b10000;
  localparam logic [4:0] ALU_INC = 5'b11111;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
`ifdef CU_MULDIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ROR, OP_ROL, OP_AND, OP_OR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] alu_map(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mini_src_control_unit_reg_select.sv
// Register-field decoder: 4-bit GPR number to one-hot select, all zero when disabled.
module mini_src_reg_select #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       sel_i,
  input  logic             en_i,
  output logic [NREGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0-T2, R-format execute T3-T5/T6.
// Define CU_MULDIV_EN to make MUL/DIV legal (64-bit result via ZHI/HI/LO strobes and T6).
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int ALU_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      ir,
  output logic             Pout,
  output logic             MARen,
  output logic             Pen,
  output logic             Read,
  output logic             MDRen,
  output logic             MDROut,
  output logic             IRen,
  output logic             Yen,
  output logic             ZLOen,
  output logic             ZHIen,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             HIen,
  output logic             LOen,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic [ALU_W-1:0] alu_control,
  output logic             halted,
  output logic             illegal_op
);

  state_e     state_q, state_d;
  logic [4:0] op_q;
  logic [3:0] ra_q, rc_q;

  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic       ir_legal, ir_halt, muldiv;
  logic       unused_ir;

  assign ir_op     = ir[31:27];
  assign ir_ra     = ir[26:23];
  assign ir_rb     = ir[22:19];
  assign ir_rc     = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign ir_legal  = is_alu(ir_op) | is_muldiv(ir_op);
  assign ir_halt   = (ir_op == OP_HALT);
  assign muldiv    = is_muldiv(op_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_rdy) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (ir_halt)       state_d = ST_HALT;
        else if (ir_legal) state_d = ST_T4;
        else               state_d = run ? ST_T0 : ST_IDLE;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = muldiv ? ST_T6 : (run ? ST_T0 : ST_IDLE);
      ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fields are captured in T3 so T4-T6 do not depend on IR staying stable.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T3) begin
        op_q <= ir_op;
        ra_q <= ir_ra;
        rc_q <= ir_rc;
      end
    end
  end

  always_comb begin
    Pout        = 1'b0;
    MARen       = 1'b0;
    Pen         = 1'b0;
    Read        = 1'b0;
    MDRen       = 1'b0;
    MDROut      = 1'b0;
    IRen        = 1'b0;
    Yen         = 1'b0;
    ZLOen       = 1'b0;
    ZHIen       = 1'b0;
    ZLOout      = 1'b0;
    ZHIout      = 1'b0;
    HIen        = 1'b0;
    LOen        = 1'b0;
    alu_control = '0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      ST_T0: begin
        Pout        = 1'b1;
        MARen       = 1'b1;
        ZLOen       = 1'b1;
        alu_control = ALU_W'(ALU_INC);
      end
      ST_T1: begin
        ZLOout = 1'b1;
        Pen    = 1'b1;
        Read   = 1'b1;
        MDRen  = 1'b1;
      end
      ST_T2: begin
        MDROut = 1'b1;
        IRen   = 1'b1;
      end
      ST_T3: begin
        Yen        = ir_legal | ir_halt;
        illegal_op = ~(ir_legal | ir_halt);
      end
      ST_T4: begin
        ZLOen       = 1'b1;
        alu_control = ALU_W'(alu_map(op_q));
`ifdef CU_MULDIV_EN
        ZHIen       = muldiv;
`endif
      end
      ST_T5: begin
        ZLOout = 1'b1;
`ifdef CU_MULDIV_EN
        LOen   = muldiv;
`endif
      end
      ST_T6: begin
`ifdef CU_MULDIV_EN
        ZHIout = 1'b1;
        HIen   = 1'b1;
`endif
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Rout uses Rb straight from IR in T3, the latched Rc in T4.
  mini_src_reg_select #(.NREGS(NREGS)) u_rout_sel (
    .sel_i    ((state_q == ST_T3) ? ir_rb : rc_q),
    .en_i     (((state_q == ST_T3) && (ir_legal || ir_halt)) || (state_q == ST_T4)),
    .onehot_o (Rout)
  );

  mini_src_reg_select #(.NREGS(NREGS)) u_rin_sel (
    .sel_i    (ra_q),
    .en_i     ((state_q == ST_T5) && !muldiv),
    .onehot_o (Rin)
  );

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Table-driven bench for mini_src_control_unit with an expected-output scoreboard queue.
module tb_mini_src_control_unit;

  logic        clk = 1'b0;
  logic        clr, run, mem_rdy;
  logic [31:0] ir;
  logic        Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen;
  logic        ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen;
  logic [15:0] Rout, Rin;
  logic [4:0]  alu_control;
  logic        halted, illegal_op;

  mini_src_control_unit #(.NREGS(16), .ALU_W(5)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .Pout(Pout), .MARen(MARen), .Pen(Pen), .Read(Read), .MDRen(MDRen),
    .MDROut(MDROut), .IRen(IRen), .Yen(Yen), .ZLOen(ZLOen), .ZHIen(ZHIen),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIen(HIen), .LOen(LOen),
    .Rout(Rout), .Rin(Rin), .alu_control(alu_control),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] s;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  alu;
    logic        h;
    logic        il;
  } out_t;

  typedef struct {
    string       name;
    logic        run;
    logic        mem_rdy;
    logic [31:0] ir;
    out_t        exp;
  } vec_t;

  localparam int S_POUT = 13, S_MAREN = 12, S_PEN = 11, S_READ = 10, S_MDREN = 9;
  localparam int S_MDROUT = 8, S_IREN = 7, S_YEN = 6, S_ZLOEN = 5, S_ZHIEN = 4;
  localparam int S_ZLOOUT = 3, S_ZHIOUT = 2, S_HIEN = 1, S_LOEN = 0;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t e_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t e_t0();
    out_t o = '0;
    o.s[S_POUT] = 1'b1; o.s[S_MAREN] = 1'b1; o.s[S_ZLOEN] = 1'b1;
    o.alu = 5'b11111;
    return o;
  endfunction

  function automatic out_t e_t1();
    out_t o = '0;
    o.s[S_ZLOOUT] = 1'b1; o.s[S_PEN] = 1'b1; o.s[S_READ] = 1'b1; o.s[S_MDREN] = 1'b1;
    return o;
  endfunction

  function automatic out_t e_t2();
    out_t o = '0;
    o.s[S_MDROUT] = 1'b1; o.s[S_IREN] = 1'b1;
    return o;
  endfunction

  function automatic out_t e_t3(input int rb);
    out_t o = '0;
    o.s[S_YEN] = 1'b1;
    o.ro = 16'h1 << rb;
    return o;
  endfunction

  function automatic out_t e_ill();
    out_t o = '0;
    o.il = 1'b1;
    return o;
  endfunction

  function automatic out_t e_t4(input int rc, input logic [4:0] alu, input logic zhi);
    out_t o = '0;
    o.s[S_ZLOEN] = 1'b1; o.s[S_ZHIEN] = zhi;
    o.ro = 16'h1 << rc;
    o.alu = alu;
    return o;
  endfunction

  function automatic out_t e_t5(input int ra, input logic md);
    out_t o = '0;
    o.s[S_ZLOOUT] = 1'b1;
    if (md) o.s[S_LOEN] = 1'b1;
    else    o.ri = 16'h1 << ra;
    return o;
  endfunction

  function automatic out_t e_t6();
    out_t o = '0;
    o.s[S_ZHIOUT] = 1'b1; o.s[S_HIEN] = 1'b1;
    return o;
  endfunction

  function automatic out_t e_halt();
    out_t o = '0;
    o.h = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.s   = {Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
             ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen};
    o.ro  = Rout;
    o.ri  = Rin;
    o.alu = alu_control;
    o.h   = halted;
    o.il  = illegal_op;
    return o;
  endfunction

  task automatic compare(input string name, input out_t e);
    out_t a;
    a = sample();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h (strobes %b Rout %h Rin %h alu %b halt %b ill %b), want %h",
               name, a, a.s, a.ro, a.ri, a.alu, a.h, a.il, e);
    end
  endtask

  task automatic add(input string n, input logic r, input logic m, input logic [31:0] i,
                     input out_t e);
    vec_t v;
    v.name = n; v.run = r; v.mem_rdy = m; v.ir = i; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic run_table();
    foreach (tbl[k]) begin
      run     = tbl[k].run;
      mem_rdy = tbl[k].mem_rdy;
      ir      = tbl[k].ir;
      exp_q.push_back(tbl[k].exp);
      @(posedge clk);
      #1;
      compare(tbl[k].name, exp_q.pop_front());
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ir_shl, ir_ill, ir_halt, ir_mul, ir_add;
    ir_shl  = 32'h28918000;
    ir_ill  = 32'hF0000000;
    ir_halt = 32'hD8000000;
    ir_mul  = {5'b01111, 4'd3, 4'd4, 4'd5, 15'd0};
    ir_add  = {5'b00011, 4'd7, 4'd8, 4'd9, 15'd0};

    clr = 1'b0; run = 1'b0; mem_rdy = 1'b1; ir = '0;
    #1 clr = 1'b1;
    #1 compare("reset_async", e_idle());
    @(posedge clk); #1;
    compare("reset_held", e_idle());
    clr = 1'b0;

    // shl through fetch and execute, then a fetch stall into an illegal opcode
    add("idle_run0", 0, 1, ir_shl, e_idle());
    add("shl_t0",    1, 1, ir_shl, e_t0());
    add("shl_t1",    1, 1, ir_shl, e_t1());
    add("shl_t2",    1, 1, ir_shl, e_t2());
    add("shl_t3",    1, 1, ir_shl, e_t3(2));
    add("shl_t4",    1, 1, ir_shl, e_t4(3, 5'b00111, 1'b0));
    add("shl_t5",    1, 1, ir_shl, e_t5(1, 1'b0));
    add("shl_next",  1, 1, ir_shl, e_t0());
    for (int i = 0; i < 4; i++) add("stall_t1", 1, 0, ir_ill, e_t1());
    add("stall_t2",  1, 1, ir_ill, e_t2());
    add("ill_t3",    1, 1, ir_ill, e_ill());
    add("ill_next",  1, 1, ir_ill, e_t0());
    add("ill2_t1",   1, 1, ir_ill, e_t1());
    add("ill2_t2",   0, 1, ir_ill, e_t2());
    add("ill2_t3",   0, 1, ir_ill, e_ill());
    add("ill2_idle", 0, 1, ir_ill, e_idle());
    add("idle_stay", 0, 1, ir_ill, e_idle());
    add("halt_t0",   1, 1, ir_halt, e_t0());
    add("halt_t1",   1, 1, ir_halt, e_t1());
    add("halt_t2",   1, 1, ir_halt, e_t2());
    add("halt_t3",   1, 1, ir_halt, e_t3(0));
    for (int i = 0; i < 21; i++) add("halt_hold", 1, 1, ir_halt, e_halt());
    run_table();

    clr = 1'b1;
    #1 compare("halt_clr", e_idle());
    @(posedge clk); #1;
    compare("halt_clr_held", e_idle());
    clr = 1'b0;

    add("mul_t0", 1, 1, ir_mul, e_t0());
    add("mul_t1", 1, 1, ir_mul, e_t1());
    add("mul_t2", 1, 1, ir_mul, e_t2());
`ifdef CU_MULDIV_EN
    add("mul_t3",   1, 1, ir_mul, e_t3(4));
    add("mul_t4",   1, 1, ir_mul, e_t4(5, 5'b01111, 1'b1));
    add("mul_t5",   1, 1, ir_mul, e_t5(3, 1'b1));
    add("mul_t6",   0, 1, ir_mul, e_t6());
    add("mul_idle", 0, 1, ir_mul, e_idle());
`else
    add("mul_ill",  0, 1, ir_mul, e_ill());
    add("mul_idle", 0, 1, ir_mul, e_idle());
`endif
    // run dropped mid-instruction: add still completes, then IDLE
    add("add_t0",   1, 1, ir_add, e_t0());
    add("add_t1",   1, 1, ir_add, e_t1());
    add("add_t2",   0, 1, ir_add, e_t2());
    add("add_t3",   0, 1, ir_add, e_t3(8));
    add("add_t4",   0, 1, ir_add, e_t4(9, 5'b00011, 1'b0));
    add("add_t5",   0, 1, ir_add, e_t5(7, 1'b0));
    add("add_idle", 0, 1, ir_add, e_idle());
    add("add2_t0",  1, 1, ir_add, e_t0());
    add("add2_t1",  1, 1, ir_add, e_t1());
    add("add2_t2",  1, 1, ir_add, e_t2());
    add("add2_t3",  1, 1, ir_add, e_t3(8));
    add("add2_t4",  1, 1, ir_add, e_t4(9, 5'b00011, 1'b0));
    run_table();

    // asynchronous clear in the middle of T4
    #2 clr = 1'b1;
    #1 compare("clr_in_t4", e_idle());
    @(posedge clk); #1;
    compare("clr_t4_held", e_idle());
    clr = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    compare("clr_release_t0", e_t0());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
